// File: rtl/chunked_adder.sv
// Multi-cycle add/subtract: one CHUNK-wide slice, registered carry between slices; optional accumulate mode via CHUNKED_ADDER_ACC_EN.
// Latency: start sampled at E0, done pulse and updated sum/cout/ovf after edge EN (N = WIDTH/CHUNK).
// Backpressure: start is ignored while busy=1; a start during the done cycle is accepted.
`timescale 1ns/1ps

module chunked_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
`ifdef CHUNKED_ADDER_ACC_EN
  input  logic             acc,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  // Number of chunk cycles and the width of the chunk index counter.
  localparam int N    = WIDTH / CHUNK;
  localparam int IDXW = (N > 1) ? $clog2(N) : 1;
  localparam int MSB  = WIDTH - 1;

  localparam logic [IDXW-1:0]  LAST_IDX   = IDXW'(N - 1);
  localparam logic [WIDTH-1:0] CHUNK_MASK = WIDTH'({CHUNK{1'b1}});

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  // Control state.
  state_t           state_q, state_d;
  logic [IDXW-1:0]  idx_q,   idx_d;

  // Operands captured at start (b already conditioned for subtract).
  logic [WIDTH-1:0] a_q,     a_d;
  logic [WIDTH-1:0] b_q,     b_d;
  logic             carry_q, carry_d;

  // Partial result assembled one chunk at a time.
  logic [WIDTH-1:0] work_q,  work_d;

  // Registered outputs; they move only on the done edge (or reset).
  logic [WIDTH-1:0] sum_q,   sum_d;
  logic             cout_q,  cout_d;
  logic             ovf_q,   ovf_d;
  logic             done_q,  done_d;
  logic             busy_q,  busy_d;

  // Operand conditioning at start.
  logic [WIDTH-1:0] a_sel;
  logic [WIDTH-1:0] b_eff;
  logic             c_eff;

  // Datapath of the single chunk slice.
  int               base;
  logic [CHUNK-1:0] a_chunk;
  logic [CHUNK-1:0] b_chunk;
  logic [CHUNK:0]   chunk_res;
  logic [WIDTH-1:0] work_next;

`ifdef CHUNKED_ADDER_ACC_EN
  // In accumulate mode the previous result replaces operand a.
  assign a_sel = acc ? sum_q : a;
`else
  assign a_sel = a;
`endif

  // Subtract is a + ~b + 1; a borrow-in flips the injected carry.
  assign b_eff = b ^ {WIDTH{sub}};
  assign c_eff = cin ^ sub;

  // Select the current chunk of each operand and add it with the carried bit.
  always_comb begin
    base      = int'(idx_q) * CHUNK;
    a_chunk   = CHUNK'(a_q >> base);
    b_chunk   = CHUNK'(b_q >> base);
    chunk_res = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry_q};
    work_next = (work_q & ~(CHUNK_MASK << base))
              | (WIDTH'(chunk_res[CHUNK-1:0]) << base);
  end

  // Next-state logic for the IDLE/RUN sequencer and the result registers.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    work_d  = work_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    busy_d  = busy_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = a_sel;
          b_d     = b_eff;
          carry_d = c_eff;
          idx_d   = '0;
          work_d  = '0;
          busy_d  = 1'b1;
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        work_d  = work_next;
        carry_d = chunk_res[CHUNK];
        idx_d   = idx_q + IDXW'(1);
        if (idx_q == LAST_IDX) begin
          // Last chunk: publish the full result and flags, drop busy.
          sum_d   = work_next;
          cout_d  = chunk_res[CHUNK];
          ovf_d   = (a_q[MSB] == b_q[MSB]) && (work_next[MSB] != a_q[MSB]);
          done_d  = 1'b1;
          busy_d  = 1'b0;
          idx_d   = '0;
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State registers; reset aborts any operation in flight without a done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      work_q  <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      work_q  <= work_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_chunked_adder.sv
// Directed bench for chunked_adder (WIDTH=16, CHUNK=4) with a result scoreboard.
// Expected results are computed at issue time and compared when done pulses.
// Accumulate-mode expectations follow CHUNKED_ADDER_ACC_EN when it is defined.
`timescale 1ns/1ps

module tb_chunked_adder;

  localparam int WIDTH = 16;
  localparam int CHUNK = 4;
  localparam int N     = WIDTH / CHUNK;

`ifdef CHUNKED_ADDER_ACC_EN
  localparam bit ACC_EN = 1'b1;
`else
  localparam bit ACC_EN = 1'b0;
`endif

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
  } exp_t;

  logic             clk;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             acc;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  int               errors = 0;
  int               checks = 0;
  exp_t             sb[$];
  logic [WIDTH-1:0] model_sum;

  chunked_adder #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .sub   (sub),
`ifdef CHUNKED_ADDER_ACC_EN
    .acc   (acc),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  // Drive a start request now and push its expected result.
  task automatic issue(input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib,
                       input logic icin, input logic isub, input logic iacc);
    logic [WIDTH-1:0] a_used;
    logic [WIDTH-1:0] b_use;
    logic [WIDTH:0]   full;
    exp_t             e;
    a     = ia;
    b     = ib;
    cin   = icin;
    sub   = isub;
    acc   = iacc;
    start = 1'b1;
    a_used = (ACC_EN && iacc) ? model_sum : ia;
    b_use  = isub ? ~ib : ib;
    full   = {1'b0, a_used} + {1'b0, b_use} + (WIDTH+1)'(icin ^ isub);
    e.sum  = full[WIDTH-1:0];
    e.cout = full[WIDTH];
    e.ovf  = (a_used[WIDTH-1] == b_use[WIDTH-1]) && (full[WIDTH-1] != a_used[WIDTH-1]);
    sb.push_back(e);
  endtask

  // Follow one operation from E0 to its done pulse and score the result.
  task automatic finish(input string tag, input int glitch_at, input bit keep);
    int               got;
    exp_t             e;
    logic [WIDTH-1:0] held;
    held = model_sum;
    got  = 0;
    @(negedge clk);
    if (!keep) start = 1'b0;
    check({tag, ".busy_e0"}, busy, 1);
    check({tag, ".done_e0"}, done, 0);
    for (int k = 1; k <= N + 4; k++) begin
      @(negedge clk);
      if (glitch_at > 0 && k == glitch_at + 1) start = 1'b0;
      if (done) begin
        got = k;
        break;
      end
      check({tag, ".busy_run"}, busy, 1);
      check({tag, ".sum_held"}, sum, held);
      if (k == glitch_at) begin
        start = 1'b1;
        a     = a ^ 16'h5a5a;
        b     = b ^ 16'h0f0f;
        sub   = ~sub;
      end
    end
    check({tag, ".latency"}, got, N);
    check({tag, ".busy_done"}, busy, 0);
    check({tag, ".sb_depth"}, sb.size(), 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, ".sum"}, sum, e.sum);
      check({tag, ".cout"}, cout, e.cout);
      check({tag, ".ovf"}, ovf, e.ovf);
      model_sum = e.sum;
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; acc = 1'b0;
    model_sum = '0;
    repeat (2) @(negedge clk);
    check("rst.busy", busy, 0);
    check("rst.done", done, 0);
    check("rst.sum", sum, 0);
    check("rst.cout", cout, 0);
    check("rst.ovf", ovf, 0);
    rst = 1'b0;

    // Plain add.
    @(negedge clk); issue(16'h1234, 16'h0FED, 1'b0, 1'b0, 1'b0); finish("add", 0, 0);
    check("add.const", sum, 16'h2221);

    // Carry ripple through every chunk, then signed overflow.
    @(negedge clk); issue(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0); finish("ripple", 0, 0);
    check("ripple.const_sum", sum, 16'h0000);
    check("ripple.const_cout", cout, 1);
    @(negedge clk); issue(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0); finish("povf", 0, 0);
    check("povf.const_ovf", ovf, 1);

    // Subtract with and without borrow, including negative overflow.
    @(negedge clk); issue(16'h0005, 16'h0007, 1'b0, 1'b1, 1'b0); finish("sub", 0, 0);
    check("sub.const", sum, 16'hFFFE);
    @(negedge clk); issue(16'h8000, 16'h0001, 1'b0, 1'b1, 1'b0); finish("nsub", 0, 0);
    check("nsub.const_ovf", ovf, 1);
    @(negedge clk); issue(16'h00FF, 16'h0001, 1'b1, 1'b0, 1'b0); finish("addc", 0, 0);
    check("addc.const", sum, 16'h0101);
    @(negedge clk); issue(16'h0010, 16'h0003, 1'b1, 1'b1, 1'b0); finish("subb", 0, 0);
    check("subb.const", sum, 16'h000C);

    // Start pulsed at E2 with different operands must be ignored.
    @(negedge clk); issue(16'h1111, 16'h2222, 1'b0, 1'b0, 1'b0); finish("glitch", 1, 0);
    check("glitch.const", sum, 16'h3333);

    // Start held through the done cycle: back-to-back operation.
    @(negedge clk); issue(16'h4000, 16'h4000, 1'b0, 1'b0, 1'b0); finish("b2b1", 0, 1);
    issue(16'h0F0F, 16'h0101, 1'b0, 1'b1, 1'b0); finish("b2b2", 0, 0);
    check("b2b2.const", sum, 16'h0E0E);
    @(negedge clk);
    check("b2b2.done_pulse", done, 0);

    // Asynchronous reset mid-RUN aborts the operation.
    issue(16'h0AAA, 16'h0555, 1'b0, 1'b0, 1'b0);
    @(negedge clk); start = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort.busy", busy, 0);
    check("abort.done", done, 0);
    check("abort.sum", sum, 0);
    check("abort.cout", cout, 0);
    check("abort.ovf", ovf, 0);
    void'(sb.pop_back());
    model_sum = '0;
    @(negedge clk); #2 rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("abort.no_done", done, 0);
      check("abort.idle", busy, 0);
    end

    // Recovery, then accumulate (acc ignored when the feature is absent).
    @(negedge clk); issue(16'h0010, 16'h0000, 1'b0, 1'b0, 1'b0); finish("post", 0, 0);
    check("post.const", sum, 16'h0010);
    @(negedge clk); issue(16'hBEEF, 16'h0003, 1'b0, 1'b0, 1'b1); finish("acc", 0, 0);
    check("acc.const", sum, ACC_EN ? 32'h0013 : 32'hBEF2);

    // A few random operations against the model.
    for (int r = 0; r < 6; r++) begin
      @(negedge clk);
      issue(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      finish("rand", 0, 0);
    end

    @(negedge clk); start = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
